// File: rtl/ahb_matrix_pkg.sv
// Shared definitions for the AHB matrix blocks (input stage, output stage, arbiter).
// Holds the HTRANS/HRESP codes, the input-stage FSM state type and the
// address/control bundle that an input stage captures while waiting for a grant.
package ahb_matrix_pkg;

    localparam logic [1:0] HtransIdle   = 2'b00;
    localparam logic [1:0] HtransBusy   = 2'b01;
    localparam logic [1:0] HtransNonseq = 2'b10;
    localparam logic [1:0] HtransSeq    = 2'b11;

    localparam logic HrespOkay  = 1'b0;
    localparam logic HrespError = 1'b1;

    typedef enum logic [1:0] {
        StIdle = 2'b00,  // no transfer outstanding
        StPend = 2'b01,  // address phase held, awaiting grant
        StData = 2'b10   // data phase in progress downstream
    } in_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic [3:0]  master;
        logic        mastlock;
    } addr_ctrl_t;

endpackage

// File: rtl/ahb_input_stage_dmam_if.sv
// Signal bundle around one AHB matrix input stage.
// Master side: H*S address/control in, HREADYS in, HREADYOUTS/HRESPS out.
// Output-stage side: *_ip / master_op forwarded address/control and held_tran_ip out,
// active_ip/readyout_ip/resp_ip in.
// Modport slave is the input stage's view; modport master is the environment's view.
interface ahb_input_stage_dmam_if;

    logic        HSELS;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic        HWRITES;
    logic [2:0]  HSIZES;
    logic [2:0]  HBURSTS;
    logic [3:0]  HPROTS;
    logic [3:0]  HMASTERS;
    logic        HMASTLOCKS;
    logic        HREADYS;
    logic        HREADYOUTS;
    logic        HRESPS;

    logic        sel_ip;
    logic [31:0] addr_ip;
    logic [1:0]  trans_ip;
    logic        write_ip;
    logic [2:0]  size_ip;
    logic [2:0]  burst_ip;
    logic [3:0]  prot_ip;
    logic [3:0]  master_op;
    logic        mastlock_ip;
    logic        held_tran_ip;
    logic        active_ip;
    logic        readyout_ip;
    logic        resp_ip;

    modport slave (
        input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTERS,
               HMASTLOCKS, HREADYS, active_ip, readyout_ip, resp_ip,
        output HREADYOUTS, HRESPS, sel_ip, addr_ip, trans_ip, write_ip, size_ip,
               burst_ip, prot_ip, master_op, mastlock_ip, held_tran_ip
    );

    modport master (
        output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTERS,
               HMASTLOCKS, HREADYS, active_ip, readyout_ip, resp_ip,
        input  HREADYOUTS, HRESPS, sel_ip, addr_ip, trans_ip, write_ip, size_ip,
               burst_ip, prot_ip, master_op, mastlock_ip, held_tran_ip
    );

endinterface

// File: rtl/ahb_input_stage_dmam.sv
// AHB matrix input stage.
// Passes a master's address phase straight to the output stage when granted; otherwise
// captures it into a hold register and stalls the master (HREADYOUTS=0) until the
// output stage grants this port. Data-phase ready/response are forwarded from the
// granted output stage.
// Ports: HCLK (clock), HRESET (async active-high reset), bus (slave modport of
// ahb_input_stage_dmam_if carrying the master-side and output-stage-side signals).
module ahb_input_stage_dmam
    import ahb_matrix_pkg::*;
(
    input  logic                  HCLK,
    input  logic                  HRESET,
    ahb_input_stage_dmam_if.slave bus
);

    in_state_e  state_q, state_d;
    addr_ctrl_t hold_q, hold_d;
    addr_ctrl_t live;
    addr_ctrl_t fwd;
    logic       live_valid;
    logic       held_tran;
    logic       accept;

    always_comb begin
        live.addr     = bus.HADDRS;
        live.trans    = bus.HTRANSS;
        live.write    = bus.HWRITES;
        live.size     = bus.HSIZES;
        live.burst    = bus.HBURSTS;
        live.prot     = bus.HPROTS;
        live.master   = bus.HMASTERS;
        live.mastlock = bus.HMASTLOCKS;
    end

    assign live_valid = bus.HSELS & bus.HTRANSS[1] & bus.HREADYS;

    // Output multiplexer: held copy in PEND, live inputs otherwise.
    always_comb begin
        fwd        = live;
        bus.sel_ip = bus.HSELS;
        held_tran  = live_valid;
        if (state_q == StPend) begin
            fwd        = hold_q;
            // A held SEQ/NONSEQ is reissued as the first beat of a new access.
            fwd.trans  = HtransNonseq;
            bus.sel_ip = 1'b1;
            held_tran  = 1'b1;
        end
        // Reset also quiets the combinational path so nothing is offered downstream.
        if (HRESET) begin
            fwd.trans = HtransIdle;
            held_tran = 1'b0;
        end
    end

    assign bus.addr_ip      = fwd.addr;
    assign bus.trans_ip     = fwd.trans;
    assign bus.write_ip     = fwd.write;
    assign bus.size_ip      = fwd.size;
    assign bus.burst_ip     = fwd.burst;
    assign bus.prot_ip      = fwd.prot;
    assign bus.master_op    = fwd.master;
    assign bus.mastlock_ip  = fwd.mastlock;
    assign bus.held_tran_ip = held_tran;

    assign accept = held_tran & bus.active_ip & bus.readyout_ip;

    // Master-facing ready/response.
    always_comb begin
        bus.HREADYOUTS = 1'b1;
        bus.HRESPS     = HrespOkay;
        unique case (state_q)
            StPend: begin
                bus.HREADYOUTS = 1'b0;
            end
            StData: begin
                bus.HREADYOUTS = bus.readyout_ip;
                bus.HRESPS     = bus.resp_ip;
            end
            default: begin
                bus.HREADYOUTS = 1'b1;
                bus.HRESPS     = HrespOkay;
            end
        endcase
    end

    // Next-state and hold-register capture.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        unique case (state_q)
            StPend: begin
                if (accept) begin
                    state_d = StData;
                end
            end
            default: begin
                if (live_valid && accept) begin
                    state_d = StData;
                end else if (live_valid) begin
                    state_d = StPend;
                    hold_d  = live;
                end else if (bus.readyout_ip || (state_q == StIdle)) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= StIdle;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: doc/ahb_input_stage_dmam.md
AHB_INPUT_STAGE_DMAM -- requirements
Module: ahb_input_stage_dmam

Interface
REQ-001 HCLK  input  1  AHB system clock; all state changes on the rising edge.
REQ-002 HRESET  input  1  reset, asynchronous and active-high; one clock, no other reset.
REQ-003 HSELS  input  1  / sel_ip  output  1  master-side select / forwarded select.
REQ-004 HADDRS  input  32  / addr_ip  output  32  address.
REQ-005 HTRANSS  input  2  / trans_ip  output  2  transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
REQ-006 HWRITES / write_ip  1 each; HSIZES / size_ip  3 each; HBURSTS / burst_ip  3 each; input/output pairs, forwarded control.
REQ-007 HPROTS / prot_ip  4 each; HMASTERS / master_op  4 each; HMASTLOCKS / mastlock_ip  1 each; input/output pairs, forwarded control.
REQ-008 HREADYS  input  1  master-side bus HREADY, the address-phase sampling qualifier.
REQ-009 HREADYOUTS  output  1  ready returned to the master.
REQ-010 HRESPS  output  1  response returned to the master (0=OKAY, 1=ERROR).
REQ-011 held_tran_ip  output  1  a valid transfer is presented to the output stage.
REQ-012 active_ip  input  1  output stage has granted this port (combinational, same cycle).
REQ-013 readyout_ip  input  1  HREADYMUXM of the granted output stage.
REQ-014 resp_ip  input  1  slave HRESP routed back from the output stage.

Function
REQ-015 live_valid SHALL be HSELS & HTRANSS[1] & HREADYS; accept SHALL be held_tran_ip & active_ip & readyout_ip.
REQ-016 The FSM SHALL have three states: IDLE (no transfer outstanding), PEND (address phase held, awaiting grant) and DATA (data phase in progress downstream).
REQ-017 IDLE/DATA transitions: if live_valid and accept, go to DATA; if live_valid and not accept, capture all address/control inputs into the hold register and go to PEND; if no live_valid and readyout_ip (or state is IDLE), go to IDLE.
REQ-018 PEND transitions: on accept, go to DATA; otherwise stay in PEND with the hold register frozen.
REQ-019 In PEND, the outputs SHALL come from the hold register, with sel_ip=1, held_tran_ip=1, and trans_ip forced to NONSEQ (10), whatever the captured type.
REQ-020 In IDLE/DATA, the outputs SHALL pass the live inputs through combinationally, and held_tran_ip SHALL equal live_valid.
REQ-021 HREADYOUTS SHALL be 0 in PEND, readyout_ip in DATA and 1 in IDLE; HRESPS SHALL be resp_ip in DATA and 0 otherwise.
REQ-022 A two-cycle ERROR (resp_ip=1 with readyout_ip=0, then resp_ip=1 with readyout_ip=1) SHALL be forwarded cycle-exact.
REQ-023 If the master drives IDLE after an ERROR, the FSM SHALL go to IDLE with no held transfer.
REQ-024 An unselected or IDLE/BUSY transfer SHALL receive a zero-wait OKAY and SHALL never enter PEND.
REQ-025 A hold SHALL add exactly one or more wait cycles, equal to the cycles spent without a grant; the un-held path SHALL add zero latency.
REQ-026 mastlock_ip SHALL follow the same live-or-held selection as the other control outputs, so a held locked transfer still presents HMASTLOCK.

Reset
REQ-027 On HRESET=1, asynchronously: state IDLE, hold register all-zero, HREADYOUTS=1, HRESPS=0, held_tran_ip=0, trans_ip=00.
REQ-028 Reset asserted mid-PEND or mid-DATA SHALL discard the transfer; operation SHALL resume on the first rising edge after HRESET falls.

Structure
REQ-029 A shared package ahb_matrix_pkg SHALL hold the HTRANS codes, the HRESP codes and the FSM state enumeration; the output stage and arbiter reuse it.
REQ-030 The block SHALL be a single module with no sub-module; the hold register and the output multiplexer are inline.

Verification
REQ-031 Direct accept: HSELS=1, NONSEQ, HADDRS=0x2000_0010, active_ip=1, readyout_ip=1 -> held_tran_ip=1 and addr_ip=0x2000_0010 the same cycle; next cycle state DATA and HREADYOUTS follows readyout_ip.
REQ-032 Held transfer: SEQ to 0x0000_0104 with active_ip=0 for 3 cycles -> HREADYOUTS=0 for 3 cycles, then trans_ip=10, addr_ip=0x0000_0104 and HREADYOUTS=1 only after grant.
REQ-033 Two-cycle ERROR: in DATA, resp_ip=1 with readyout_ip 0 then 1 -> HRESPS=1 both cycles and HREADYOUTS 0 then 1; master drives IDLE -> state IDLE.
REQ-034 Reset in PEND: assert HRESET during a 2-cycle hold -> held_tran_ip=0 and HREADYOUTS=1 immediately; after release, no stale transfer is reissued.
REQ-035 HSELS=0 with NONSEQ, and HSELS=1 with BUSY -> held_tran_ip=0, HREADYOUTS=1, HRESPS=0; state remains IDLE.
